// File: rtl/pmu_lock_regbank.sv
// pmu_lock_regbank: lock-protected control register bank for the PMU core.
// A correct key write arms a one-shot unlock window during which a single
// register write may commit. Debug mode never grants write permission and
// closes an open window. MAX_FAILS wrong keys latch a lockout that only
// reset clears.
//
// Write handshake: io_wr_valid is a single-cycle strobe with no ready; every
// write sampled outside reset is answered exactly one cycle later by a
// one-cycle io_wr_resp_valid pulse, with io_wr_resp_err qualifying it.
// Back-to-back strobes give back-to-back responses in request order.
module pmu_lock_regbank #(
  parameter int               WIDTH         = 32,
  parameter int               N_REGS        = 4,
  parameter int               AW            = $clog2(N_REGS),
  parameter logic [WIDTH-1:0] KEY           = WIDTH'(32'h0051_F15E),
  parameter int               UNLOCK_WINDOW = 8,
  parameter int               MAX_FAILS     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_wr_valid,
  input  logic                    io_wr_key,
  input  logic [AW-1:0]           io_wr_addr,
  input  logic [WIDTH-1:0]        io_wr_data,
  input  logic                    io_debug_mode,
  input  logic [AW-1:0]           io_rd_addr,
  output logic [WIDTH-1:0]        io_rd_data,
  output logic [N_REGS*WIDTH-1:0] io_regs_q,
  output logic                    io_wr_resp_valid,
  output logic                    io_wr_resp_err,
  output logic                    io_unlocked,
  output logic                    io_lockout
);

  // Fail counter must hold the value MAX_FAILS itself (saturation point).
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int WW = UNLOCK_WINDOW;
  localparam logic [WW-1:0] WIN_LOAD = WW'(UNLOCK_WINDOW - 1);

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WW-1:0]    r_win_cnt;
  logic [WW-1:0]    w_win_nxt;
  logic [FW-1:0]    r_fail_cnt;
  logic [FW-1:0]    w_fail_nxt;

  logic             w_key_ok;
  logic             w_addr_ok;
  logic             w_fail_hit;
  logic             w_wr_en;
  logic             w_resp_err;

  logic             r_resp_valid;
  logic             r_resp_err;
  logic [WIDTH-1:0] r_regs [N_REGS];

  // Request decode shared by next-state and output logic.
  assign w_key_ok   = (io_wr_data == KEY);
  assign w_addr_ok  = (32'(io_wr_addr) < 32'(N_REGS));
  // This wrong key is the one that reaches the lockout threshold.
  assign w_fail_hit = ((32'(r_fail_cnt) + 32'd1) >= 32'(MAX_FAILS));

  // State and counter registers; reset returns to LOCKED with counters clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_LOCKED;
      r_win_cnt  <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_win_cnt  <= w_win_nxt;
      r_fail_cnt <= w_fail_nxt;
    end
  end

  // Next-state and counter update. Debug mode wins over any request, a
  // register write always consumes the arm, and expiry is only evaluated
  // in cycles without a write.
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win_cnt;
    w_fail_nxt  = r_fail_cnt;
    unique case (r_state)
      ST_LOCKED, ST_ARMED: begin
        if (io_debug_mode) begin
          w_state_nxt = ST_LOCKED;
        end else if (io_wr_valid && io_wr_key) begin
          if (w_key_ok) begin
            w_state_nxt = ST_ARMED;
            w_win_nxt   = WIN_LOAD;
            w_fail_nxt  = '0;
          end else begin
            if (32'(r_fail_cnt) < 32'(MAX_FAILS)) begin
              w_fail_nxt = r_fail_cnt + 1'b1;
            end
            w_state_nxt = w_fail_hit ? ST_LOCKOUT : ST_LOCKED;
          end
        end else if (io_wr_valid) begin
          w_state_nxt = ST_LOCKED;
        end else if (r_state == ST_ARMED) begin
          if (r_win_cnt == '0) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_win_nxt = r_win_cnt - 1'b1;
          end
        end
      end
      ST_LOCKOUT: begin
        w_state_nxt = ST_LOCKOUT;
      end
      default: begin
        w_state_nxt = ST_LOCKED;
      end
    endcase
  end

  // Outputs: status decoded from the state register only, plus the write
  // enable and response verdict. Debug mode only ever blocks a write.
  always_comb begin
    io_unlocked = (r_state == ST_ARMED);
    io_lockout  = (r_state == ST_LOCKOUT);
    w_wr_en     = 1'b0;
    w_resp_err  = 1'b1;
    if (io_wr_valid && !io_debug_mode && (r_state != ST_LOCKOUT)) begin
      if (io_wr_key) begin
        w_resp_err = !w_key_ok;
      end else if ((r_state == ST_ARMED) && w_addr_ok) begin
        w_wr_en    = 1'b1;
        w_resp_err = 1'b0;
      end
    end
  end

  // Write response pipeline: one pulse per sampled strobe, none in reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= io_wr_valid;
      r_resp_err   <= io_wr_valid & w_resp_err;
    end
  end

  assign io_wr_resp_valid = r_resp_valid;
  assign io_wr_resp_err   = r_resp_err;

  // Register storage: commit on the edge that samples an accepted write.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REGS; i++) begin
      if (reset) begin
        r_regs[i] <= RESET_VAL;
      end else if (w_wr_en && (io_wr_addr == AW'(i))) begin
        r_regs[i] <= io_wr_data;
      end
    end
  end

  // Zero-latency read port; addresses with no register read as zero.
  always_comb begin
    io_rd_data = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (io_rd_addr == AW'(i)) begin
        io_rd_data = r_regs[i];
      end
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_regs_q
    assign io_regs_q[g*WIDTH +: WIDTH] = r_regs[g];
  end

endmodule

// File: tb/tb_pmu_lock_regbank.sv
// Self-checking bench for pmu_lock_regbank with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge; write
// responses are checked against an expected queue filled by the driver.
`timescale 1ns/1ps
module tb_pmu_lock_regbank;

  localparam int WIDTH  = 32;
  localparam int N_REGS = 4;
  localparam int AW     = 2;
  localparam logic [WIDTH-1:0] KEY = 32'h0051_F15E;

  logic                    clock;
  logic                    reset;
  logic                    io_wr_valid;
  logic                    io_wr_key;
  logic [AW-1:0]           io_wr_addr;
  logic [WIDTH-1:0]        io_wr_data;
  logic                    io_debug_mode;
  logic [AW-1:0]           io_rd_addr;
  logic [WIDTH-1:0]        io_rd_data;
  logic [N_REGS*WIDTH-1:0] io_regs_q;
  logic                    io_wr_resp_valid;
  logic                    io_wr_resp_err;
  logic                    io_unlocked;
  logic                    io_lockout;

  logic [0:0]       exp_q[$];
  logic [0:0]       mon_exp;
  logic [WIDTH-1:0] exp_regs [N_REGS];
  int               n_tests = 0;
  int               n_fail  = 0;

  pmu_lock_regbank dut (
    .clock            (clock),
    .reset            (reset),
    .io_wr_valid      (io_wr_valid),
    .io_wr_key        (io_wr_key),
    .io_wr_addr       (io_wr_addr),
    .io_wr_data       (io_wr_data),
    .io_debug_mode    (io_debug_mode),
    .io_rd_addr       (io_rd_addr),
    .io_rd_data       (io_rd_data),
    .io_regs_q        (io_regs_q),
    .io_wr_resp_valid (io_wr_resp_valid),
    .io_wr_resp_err   (io_wr_resp_err),
    .io_unlocked      (io_unlocked),
    .io_lockout       (io_lockout)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (io_wr_resp_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got response err=%0b, required no response", io_wr_resp_err);
      end else begin
        mon_exp = exp_q.pop_front();
        if (io_wr_resp_err !== mon_exp[0]) begin
          n_fail++;
          $display("FAIL resp_err: got %0b, required %0b (t=%0t)", io_wr_resp_err, mon_exp[0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end exactly on a falling edge (or #1 after one).
  task automatic apply_reset(input logic with_write, input logic [AW-1:0] addr,
                             input logic [WIDTH-1:0] data);
    reset       = 1'b1;
    io_wr_valid = with_write;
    io_wr_key   = 1'b0;
    io_wr_addr  = addr;
    io_wr_data  = data;
    @(negedge clock);
    reset       = 1'b0;
    io_wr_valid = 1'b0;
    io_wr_data  = '0;
    for (int i = 0; i < N_REGS; i++) exp_regs[i] = '0;
  endtask

  task automatic do_write(input logic key, input logic [AW-1:0] addr,
                          input logic [WIDTH-1:0] data, input logic exp_err);
    io_wr_valid = 1'b1;
    io_wr_key   = key;
    io_wr_addr  = addr;
    io_wr_data  = data;
    exp_q.push_back(exp_err);
    @(negedge clock);
    io_wr_valid = 1'b0;
    io_wr_key   = 1'b0;
    io_wr_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset(1'b0, '0, '0);
    n_tests++;
    if (io_regs_q !== '0) begin
      n_fail++; $display("FAIL reset_regs: got %h, required 0", io_regs_q);
    end
    n_tests++;
    if (io_unlocked !== 1'b0 || io_lockout !== 1'b0 || io_wr_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got unl=%0b lock=%0b rv=%0b, required 0 0 0",
               io_unlocked, io_lockout, io_wr_resp_valid);
    end
    do_write(1'b0, 2'd1, 32'hA5, 1'b1);
    io_rd_addr = 2'd1; #1;
    n_tests++;
    if (io_rd_data !== 32'h0) begin
      n_fail++; $display("FAIL locked_write: reg1 got %h, required 0", io_rd_data);
    end
  endtask

  task automatic test_unlock_write();
    do_write(1'b1, '0, KEY, 1'b0);
    idle(3);
    n_tests++;
    if (io_unlocked !== 1'b1) begin
      n_fail++; $display("FAIL armed: io_unlocked got %0b, required 1", io_unlocked);
    end
    do_write(1'b0, 2'd2, 32'hDEAD, 1'b0);
    exp_regs[2] = 32'hDEAD;
    io_rd_addr = 2'd2; #1;
    n_tests++;
    if (io_rd_data !== 32'hDEAD) begin
      n_fail++; $display("FAIL commit: reg2 got %h, required dead", io_rd_data);
    end
    n_tests++;
    if (io_unlocked !== 1'b0) begin
      n_fail++; $display("FAIL one_shot: io_unlocked got %0b, required 0", io_unlocked);
    end
    do_write(1'b0, 2'd2, 32'h1234, 1'b1);
    #1;
    n_tests++;
    if (io_rd_data !== 32'hDEAD) begin
      n_fail++; $display("FAIL second_write: reg2 got %h, required dead", io_rd_data);
    end
  endtask

  task automatic test_window();
    do_write(1'b1, '0, KEY, 1'b0);
    idle(7);
    n_tests++;
    if (io_unlocked !== 1'b1) begin
      n_fail++; $display("FAIL window_7: io_unlocked got %0b, required 1", io_unlocked);
    end
    idle(1);
    n_tests++;
    if (io_unlocked !== 1'b0) begin
      n_fail++; $display("FAIL window_8: io_unlocked got %0b, required 0", io_unlocked);
    end
    do_write(1'b0, 2'd3, 32'h77, 1'b1);
    // Boundary: write lands in the last cycle of the window.
    do_write(1'b1, '0, KEY, 1'b0);
    idle(7);
    do_write(1'b0, 2'd3, 32'h77, 1'b0);
    exp_regs[3] = 32'h77;
    // Re-arm inside the window restarts it.
    do_write(1'b1, '0, KEY, 1'b0);
    idle(5);
    do_write(1'b1, '0, KEY, 1'b0);
    idle(7);
    do_write(1'b0, 2'd0, 32'h0BAD_F00D, 1'b0);
    exp_regs[0] = 32'h0BAD_F00D;
    for (int i = 0; i < N_REGS; i++) begin
      n_tests++;
      if (io_regs_q[i*WIDTH +: WIDTH] !== exp_regs[i]) begin
        n_fail++;
        $display("FAIL window_regs[%0d]: got %h, required %h", i, io_regs_q[i*WIDTH +: WIDTH], exp_regs[i]);
      end
    end
  endtask

  task automatic test_debug();
    apply_reset(1'b0, '0, '0);
    do_write(1'b1, '0, 32'h0, 1'b1);          // fail count 1
    io_debug_mode = 1'b1;
    do_write(1'b1, '0, 32'h0, 1'b1);          // not counted
    do_write(1'b1, '0, KEY, 1'b1);            // never unlocks
    do_write(1'b0, 2'd1, 32'h55, 1'b1);
    n_tests++;
    if (io_unlocked !== 1'b0) begin
      n_fail++; $display("FAIL debug_key: io_unlocked got %0b, required 0", io_unlocked);
    end
    io_debug_mode = 1'b0;
    do_write(1'b1, '0, 32'h0, 1'b1);          // fail count 2
    n_tests++;
    if (io_lockout !== 1'b0) begin
      n_fail++; $display("FAIL debug_failcnt: io_lockout got %0b, required 0", io_lockout);
    end
    do_write(1'b1, '0, KEY, 1'b0);
    io_debug_mode = 1'b1;
    idle(1);
    io_debug_mode = 1'b0;
    n_tests++;
    if (io_unlocked !== 1'b0) begin
      n_fail++; $display("FAIL debug_cancel: io_unlocked got %0b, required 0", io_unlocked);
    end
    // Debug together with a write while armed.
    do_write(1'b1, '0, KEY, 1'b0);
    io_debug_mode = 1'b1;
    do_write(1'b0, 2'd3, 32'h99, 1'b1);
    io_debug_mode = 1'b0;
    n_tests++;
    if (io_unlocked !== 1'b0 || io_regs_q[3*WIDTH +: WIDTH] !== 32'h0) begin
      n_fail++;
      $display("FAIL debug_write: unl=%0b reg3=%h, required unl=0 reg3=0",
               io_unlocked, io_regs_q[3*WIDTH +: WIDTH]);
    end
    do_write(1'b0, 2'd3, 32'h99, 1'b1);
  endtask

  task automatic test_lockout();
    apply_reset(1'b0, '0, '0);
    do_write(1'b1, '0, 32'h0, 1'b1);
    do_write(1'b1, '0, 32'h0, 1'b1);
    n_tests++;
    if (io_lockout !== 1'b0) begin
      n_fail++; $display("FAIL lockout_early: got %0b, required 0", io_lockout);
    end
    do_write(1'b1, '0, 32'h0, 1'b1);
    n_tests++;
    if (io_lockout !== 1'b1) begin
      n_fail++; $display("FAIL lockout_set: got %0b, required 1", io_lockout);
    end
    do_write(1'b1, '0, KEY, 1'b1);
    do_write(1'b0, 2'd0, 32'h11, 1'b1);
    n_tests++;
    if (io_unlocked !== 1'b0 || io_lockout !== 1'b1 || io_regs_q !== '0) begin
      n_fail++;
      $display("FAIL lockout_hold: unl=%0b lock=%0b regs=%h, required 0 1 0",
               io_unlocked, io_lockout, io_regs_q);
    end
    apply_reset(1'b0, '0, '0);
    n_tests++;
    if (io_lockout !== 1'b0) begin
      n_fail++; $display("FAIL lockout_clear: got %0b, required 0", io_lockout);
    end
    do_write(1'b1, '0, KEY, 1'b0);
    n_tests++;
    if (io_unlocked !== 1'b1) begin
      n_fail++; $display("FAIL rearm_after_reset: io_unlocked got %0b, required 1", io_unlocked);
    end
    // Wrong key while armed drops back to LOCKED.
    do_write(1'b1, '0, 32'h0, 1'b1);
    n_tests++;
    if (io_unlocked !== 1'b0) begin
      n_fail++; $display("FAIL armed_wrong_key: io_unlocked got %0b, required 0", io_unlocked);
    end
    do_write(1'b0, 2'd1, 32'h22, 1'b1);
  endtask

  task automatic test_reset_armed();
    do_write(1'b1, '0, KEY, 1'b0);
    do_write(1'b0, 2'd0, 32'hCAFE, 1'b0);
    do_write(1'b1, '0, KEY, 1'b0);
    apply_reset(1'b1, 2'd1, 32'hBEEF);
    n_tests++;
    if (io_regs_q !== '0 || io_unlocked !== 1'b0 || io_wr_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_armed: regs=%h unl=%0b rv=%0b, required 0 0 0",
               io_regs_q, io_unlocked, io_wr_resp_valid);
    end
    do_write(1'b0, 2'd1, 32'hBEEF, 1'b1);
    n_tests++;
    if (io_regs_q[1*WIDTH +: WIDTH] !== 32'h0) begin
      n_fail++; $display("FAIL reset_armed_write: reg1 got %h, required 0", io_regs_q[1*WIDTH +: WIDTH]);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    for (int k = 0; k < 8; k++) begin
      a = AW'($urandom_range(0, N_REGS-1));
      d = $urandom;
      do_write(1'b1, '0, KEY, 1'b0);
      do_write(1'b0, a, d, 1'b0);
      exp_regs[a] = d;
      do_write(1'b0, a, ~d, 1'b1);
    end
    for (int i = 0; i < N_REGS; i++) begin
      io_rd_addr = AW'(i); #1;
      n_tests++;
      if (io_rd_data !== exp_regs[i]) begin
        n_fail++; $display("FAIL b2b_reg[%0d]: got %h, required %h", i, io_rd_data, exp_regs[i]);
      end
    end
  endtask

  task automatic drain_check(input string name);
    idle(1);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_resp: got %0d outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset         = 1'b1;
    io_wr_valid   = 1'b0;
    io_wr_key     = 1'b0;
    io_wr_addr    = '0;
    io_wr_data    = '0;
    io_debug_mode = 1'b0;
    io_rd_addr    = '0;
    test_reset();        drain_check("reset");
    test_unlock_write(); drain_check("unlock");
    test_window();       drain_check("window");
    test_debug();        drain_check("debug");
    test_lockout();      drain_check("lockout");
    test_reset_armed();  drain_check("reset_armed");
    test_back_to_back(); drain_check("b2b");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
